// File: rtl/rtc_calendar_if.sv
// Set/load and time-readout bundle for rtc_calendar.
// The alarm signals exist only when ALARM_EN is defined.
interface rtc_calendar_if #(
  parameter int YEAR_W = 12
);
  logic              set_en;
  logic [YEAR_W-1:0] set_year;
  logic [3:0]        set_month;
  logic [4:0]        set_day;
  logic [4:0]        set_hour;
  logic [5:0]        set_minute;
  logic [5:0]        set_second;
  logic [YEAR_W-1:0] year;
  logic [3:0]        month;
  logic [4:0]        day;
  logic [4:0]        hour;
  logic [5:0]        minute;
  logic [5:0]        second;
  logic              tick_1hz;
  logic              day_wrap;
  logic              set_err;
`ifdef ALARM_EN
  logic [4:0]        alarm_hour;
  logic [5:0]        alarm_minute;
  logic              alarm_arm;
  logic              alarm_clr;
  logic              alarm;
`endif

  modport master (
`ifdef ALARM_EN
    output alarm_hour, alarm_minute, alarm_arm, alarm_clr,
    input  alarm,
`endif
    output set_en, set_year, set_month, set_day, set_hour, set_minute, set_second,
    input  year, month, day, hour, minute, second, tick_1hz, day_wrap, set_err
  );

  modport slave (
`ifdef ALARM_EN
    input  alarm_hour, alarm_minute, alarm_arm, alarm_clr,
    output alarm,
`endif
    input  set_en, set_year, set_month, set_day, set_hour, set_minute, set_second,
    output year, month, day, hour, minute, second, tick_1hz, day_wrap, set_err
  );
endinterface

// File: rtl/rtc_calendar.sv
// Real-time clock/calendar: CLK_HZ prescaler to 1 Hz, hh:mm:ss plus Gregorian date, validated load.
// Define ALARM_EN to add the sticky hour:minute alarm.
module rtc_calendar #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int YEAR_W   = 12,
  parameter int RST_YEAR = 2021
) (
  input logic           clk,
  input logic           rst,
  rtc_calendar_if.slave bus
);
  localparam int            PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

  logic [PW-1:0]     pre;
  logic [YEAR_W-1:0] nxt_year;
  logic [3:0]        nxt_month;
  logic [4:0]        nxt_day;
  logic [4:0]        nxt_hour;
  logic [5:0]        nxt_minute;
  logic [5:0]        nxt_second;
  logic              nxt_wrap;
  logic              set_ok;
  logic              load_now;
  logic              tick_now;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    int unsigned yi;
    yi = 32'(y);
    return (yi % 4 == 0) && ((yi % 100 != 0) || (yi % 400 == 0));
  endfunction

  function automatic logic [4:0] month_len(input logic [YEAR_W-1:0] y, input logic [3:0] m);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
      4'd2:                    month_len = is_leap(y) ? 5'd29 : 5'd28;
      default:                 month_len = 5'd31;
    endcase
  endfunction

  // A load wins over a coincident tick; a rejected load leaves the prescaler running.
  assign set_ok = (bus.set_month >= 4'd1) && (bus.set_month <= 4'd12) &&
                  (bus.set_day >= 5'd1) && (bus.set_day <= month_len(bus.set_year, bus.set_month)) &&
                  (bus.set_hour <= 5'd23) && (bus.set_minute <= 6'd59) && (bus.set_second <= 6'd59);
  assign load_now = bus.set_en && set_ok;
  assign tick_now = !load_now && (pre == TC);

  always_comb begin
    nxt_year   = bus.year;
    nxt_month  = bus.month;
    nxt_day    = bus.day;
    nxt_hour   = bus.hour;
    nxt_minute = bus.minute;
    nxt_second = bus.second;
    nxt_wrap   = 1'b0;
    if (bus.second != 6'd59) begin
      nxt_second = bus.second + 6'd1;
    end else begin
      nxt_second = 6'd0;
      if (bus.minute != 6'd59) begin
        nxt_minute = bus.minute + 6'd1;
      end else begin
        nxt_minute = 6'd0;
        if (bus.hour != 5'd23) begin
          nxt_hour = bus.hour + 5'd1;
        end else begin
          nxt_hour = 5'd0;
          nxt_wrap = 1'b1;
          if (bus.day != month_len(bus.year, bus.month)) begin
            nxt_day = bus.day + 5'd1;
          end else begin
            nxt_day = 5'd1;
            if (bus.month != 4'd12) begin
              nxt_month = bus.month + 4'd1;
            end else begin
              nxt_month = 4'd1;
              nxt_year  = bus.year + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre          <= '0;
      bus.year     <= YEAR_W'(RST_YEAR);
      bus.month    <= 4'd1;
      bus.day      <= 5'd1;
      bus.hour     <= 5'd0;
      bus.minute   <= 6'd0;
      bus.second   <= 6'd0;
      bus.tick_1hz <= 1'b0;
      bus.day_wrap <= 1'b0;
      bus.set_err  <= 1'b0;
    end else begin
      bus.tick_1hz <= tick_now;
      bus.day_wrap <= tick_now && nxt_wrap;
      bus.set_err  <= bus.set_en && !set_ok;
      if (load_now) begin
        pre        <= '0;
        bus.year   <= bus.set_year;
        bus.month  <= bus.set_month;
        bus.day    <= bus.set_day;
        bus.hour   <= bus.set_hour;
        bus.minute <= bus.set_minute;
        bus.second <= bus.set_second;
      end else if (tick_now) begin
        pre        <= '0;
        bus.year   <= nxt_year;
        bus.month  <= nxt_month;
        bus.day    <= nxt_day;
        bus.hour   <= nxt_hour;
        bus.minute <= nxt_minute;
        bus.second <= nxt_second;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

`ifdef ALARM_EN
  // Only a tick can fire the alarm, so loading the alarm time directly never sets it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.alarm <= 1'b0;
    end else if (bus.alarm_clr) begin
      bus.alarm <= 1'b0;
    end else if (bus.alarm_arm && tick_now && (nxt_hour == bus.alarm_hour) &&
                 (nxt_minute == bus.alarm_minute) && (nxt_second == 6'd0)) begin
      bus.alarm <= 1'b1;
    end
  end
`else
  // This build carries no alarm hardware.
`endif
endmodule

// File: tb/tb_rtc_calendar.sv
// Self-checking bench for rtc_calendar (CLK_HZ=4) against a seconds-of-day/date reference model.
module tb_rtc_calendar;
  localparam int CLK_HZ = 4;
  localparam int YEAR_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int my, mmo, md, mh, mmi, ms;

  rtc_calendar_if #(.YEAR_W(YEAR_W)) bus ();

  rtc_calendar #(.CLK_HZ(CLK_HZ), .YEAR_W(YEAR_W), .RST_YEAR(2021)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic bit m_leap(int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int m_dim(int y, int mo);
    int len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo < 1 || mo > 12) return 0;
    if (mo == 2 && m_leap(y)) return 29;
    return len[mo-1];
  endfunction

  // One second forward, working in seconds-of-day and calendar days.
  task automatic m_advance(output bit wrap);
    int sod;
    sod  = mh * 3600 + mmi * 60 + ms + 1;
    wrap = (sod == 86400);
    if (wrap) begin
      sod = 0;
      md++;
      if (md > m_dim(my, mmo)) begin
        md = 1;
        mmo++;
        if (mmo > 12) begin
          mmo = 1;
          my  = (my + 1) % 4096;
        end
      end
    end
    mh  = sod / 3600;
    mmi = (sod / 60) % 60;
    ms  = sod % 60;
  endtask

  task automatic m_load(int y, int mo, int d, int h, int mi, int s);
    my = y; mmo = mo; md = d; mh = h; mmi = mi; ms = s;
  endtask

  function automatic logic [37:0] exp_vec();
    return {12'(my), 4'(mmo), 5'(md), 5'(mh), 6'(mmi), 6'(ms)};
  endfunction

  function automatic logic [37:0] dut_vec();
    return {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_set(int y, int mo, int d, int h, int mi, int s);
    bus.set_year   = 12'(y);
    bus.set_month  = 4'(mo);
    bus.set_day    = 5'(d);
    bus.set_hour   = 5'(h);
    bus.set_minute = 6'(mi);
    bus.set_second = 6'(s);
    bus.set_en     = 1'b1;
  endtask

  task automatic do_set(int y, int mo, int d, int h, int mi, int s);
    drive_set(y, mo, d, h, mi, s);
    step();
    bus.set_en = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    #1 rst = 1'b0;
    #2;
    checks++;
    if (dut_vec() !== {12'd2021, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0}) begin
      errors++; $display("[TB] FAIL reset_fields got %h want %h", dut_vec(), {12'd2021, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0});
    end
    checks++;
    if ({bus.tick_1hz, bus.day_wrap, bus.set_err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got %b want 000", {bus.tick_1hz, bus.day_wrap, bus.set_err});
    end
`ifdef ALARM_EN
    checks++;
    if (bus.alarm !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_alarm got %b want 0", bus.alarm);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    first = 0;
    for (int i = 1; i <= 12 && first == 0; i++) begin
      step();
      if (bus.tick_1hz === 1'b1) first = i;
    end
    checks++;
    if (first != CLK_HZ) begin
      errors++; $display("[TB] FAIL first_tick got cycle %0d want %0d", first, CLK_HZ);
    end
    checks++;
    if (bus.second !== 6'd1) begin
      errors++; $display("[TB] FAIL first_second got %0d want 1", bus.second);
    end
    m_load(2021, 1, 1, 0, 0, 1);
  endtask

  task automatic test_rollover(string name, int y, int mo, int d, int h, int mi, int s);
    bit wrap;
    bit early;
    m_load(y, mo, d, h, mi, s);
    do_set(y, mo, d, h, mi, s);
    checks++;
    if (dut_vec() !== exp_vec() || {bus.tick_1hz, bus.set_err} !== 2'b00) begin
      errors++; $display("[TB] FAIL %s_load got %h/%b want %h/00", name, dut_vec(), {bus.tick_1hz, bus.set_err}, exp_vec());
    end
    m_advance(wrap);
    early = 1'b0;
    for (int i = 1; i < CLK_HZ; i++) begin
      step();
      if (bus.tick_1hz !== 1'b0) early = 1'b1;
    end
    step();
    checks++;
    if (early || bus.tick_1hz !== 1'b1) begin
      errors++; $display("[TB] FAIL %s_tick got early=%b tick=%b want early=0 tick=1", name, early, bus.tick_1hz);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("[TB] FAIL %s_next got %h want %h", name, dut_vec(), exp_vec());
    end
    checks++;
    if (bus.day_wrap !== wrap) begin
      errors++; $display("[TB] FAIL %s_day_wrap got %b want %b", name, bus.day_wrap, wrap);
    end
    step();
    checks++;
    if ({bus.tick_1hz, bus.day_wrap} !== 2'b00) begin
      errors++; $display("[TB] FAIL %s_pulse_width got %b want 00", name, {bus.tick_1hz, bus.day_wrap});
    end
  endtask

  task automatic test_invalid_set();
    bit wrap;
    m_load(2023, 2, 27, 10, 20, 30);
    do_set(2023, 2, 27, 10, 20, 30);
    do_set(2023, 2, 29, 10, 0, 0);
    checks++;
    if (bus.set_err !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("[TB] FAIL invalid_feb29 got err=%b %h want err=1 %h", bus.set_err, dut_vec(), exp_vec());
    end
    step();
    checks++;
    if (bus.set_err !== 1'b0) begin
      errors++; $display("[TB] FAIL invalid_err_pulse got %b want 0", bus.set_err);
    end
    step();
    step();
    m_advance(wrap);
    checks++;
    if (bus.tick_1hz !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("[TB] FAIL invalid_keeps_count got tick=%b %h want tick=1 %h", bus.tick_1hz, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_set_on_terminal();
    bit wrap;
    bit early;
    do_set(2030, 5, 10, 12, 0, 0);
    for (int i = 1; i < CLK_HZ; i++) step();
    m_load(2031, 7, 20, 6, 45, 10);
    do_set(2031, 7, 20, 6, 45, 10);
    checks++;
    if (dut_vec() !== exp_vec() || bus.tick_1hz !== 1'b0) begin
      errors++; $display("[TB] FAIL terminal_set got %h tick=%b want %h tick=0", dut_vec(), bus.tick_1hz, exp_vec());
    end
    early = 1'b0;
    for (int i = 1; i < CLK_HZ; i++) begin
      step();
      if (bus.tick_1hz !== 1'b0) early = 1'b1;
    end
    step();
    m_advance(wrap);
    checks++;
    if (early || bus.tick_1hz !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("[TB] FAIL terminal_next_tick got early=%b tick=%b %h want 0 1 %h", early, bus.tick_1hz, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    drive_set(2010, 3, 3, 3, 3, 3);
    step();
    drive_set(2011, 4, 30, 22, 58, 7);
    step();
    bus.set_en = 1'b0;
    m_load(2011, 4, 30, 22, 58, 7);
    checks++;
    if (dut_vec() !== exp_vec() || bus.set_err !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_last_wins got %h err=%b want %h err=0", dut_vec(), bus.set_err, exp_vec());
    end
    drive_set(2012, 9, 9, 9, 9, 9);
    step();
    drive_set(2012, 9, 9, 24, 9, 9);
    step();
    bus.set_en = 1'b0;
    m_load(2012, 9, 9, 9, 9, 9);
    checks++;
    if (dut_vec() !== exp_vec() || bus.set_err !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_invalid_second got %h err=%b want %h err=1", dut_vec(), bus.set_err, exp_vec());
    end
  endtask

  task automatic test_random();
    int cnt, y, mo, d, h, mi, s;
    bit doset, ok, wrap, etick, ewrap, eerr;
    m_load(2020, 1, 1, 0, 0, 0);
    do_set(2020, 1, 1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 240; i++) begin
      y  = $urandom_range(0, 4095);
      mo = $urandom_range(0, 13);
      d  = ($urandom_range(0, 1) == 0) ? m_dim(y, mo) : $urandom_range(0, 31);
      h  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 25) : 23;
      mi = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 61) : 59;
      s  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 61) : 59 - $urandom_range(0, 2);
      ok = (mo >= 1) && (mo <= 12) && (d >= 1) && (d <= m_dim(y, mo)) && (h <= 23) && (mi <= 59) && (s <= 59);
      doset = ($urandom_range(0, 5) == 0) && (ok || cnt != CLK_HZ - 1);
      if (doset) drive_set(y, mo, d, h, mi, s);
      step();
      bus.set_en = 1'b0;
      etick = 1'b0;
      ewrap = 1'b0;
      eerr  = doset && !ok;
      if (doset && ok) begin
        m_load(y, mo, d, h, mi, s);
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == CLK_HZ) begin
          cnt = 0;
          m_advance(wrap);
          etick = 1'b1;
          ewrap = wrap;
        end
      end
      checks++;
      if (dut_vec() !== exp_vec() || {bus.tick_1hz, bus.day_wrap, bus.set_err} !== {etick, ewrap, eerr}) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d got %h flags %b want %h flags %b", i, dut_vec(),
                 {bus.tick_1hz, bus.day_wrap, bus.set_err}, exp_vec(), {etick, ewrap, eerr});
      end
    end
  endtask

  task automatic test_reset_midcount();
    do_set(2050, 8, 8, 8, 8, 8);
    step();
    step();
    rst = 1'b0;
    #2;
    checks++;
    if (dut_vec() !== {12'd2021, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0} || {bus.tick_1hz, bus.day_wrap, bus.set_err} !== 3'b000) begin
      errors++; $display("[TB] FAIL midcount_reset got %h flags %b", dut_vec(), {bus.tick_1hz, bus.day_wrap, bus.set_err});
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

`ifdef ALARM_EN
  task automatic test_alarm();
    bus.alarm_hour   = 5'd7;
    bus.alarm_minute = 6'd30;
    bus.alarm_arm    = 1'b1;
    bus.alarm_clr    = 1'b0;
    do_set(2021, 1, 1, 7, 29, 59);
    checks++;
    if (bus.alarm !== 1'b0) begin
      errors++; $display("[TB] FAIL alarm_early got %b want 0", bus.alarm);
    end
    for (int i = 0; i < CLK_HZ; i++) step();
    checks++;
    if (bus.alarm !== 1'b1) begin
      errors++; $display("[TB] FAIL alarm_fire got %b want 1", bus.alarm);
    end
    for (int i = 0; i < 3 * CLK_HZ; i++) step();
    checks++;
    if (bus.alarm !== 1'b1) begin
      errors++; $display("[TB] FAIL alarm_sticky got %b want 1", bus.alarm);
    end
    bus.alarm_clr = 1'b1;
    step();
    bus.alarm_clr = 1'b0;
    checks++;
    if (bus.alarm !== 1'b0) begin
      errors++; $display("[TB] FAIL alarm_clear got %b want 0", bus.alarm);
    end
    do_set(2021, 1, 1, 7, 30, 0);
    for (int i = 0; i < 2 * CLK_HZ; i++) step();
    checks++;
    if (bus.alarm !== 1'b0) begin
      errors++; $display("[TB] FAIL alarm_set_on_time got %b want 0", bus.alarm);
    end
    bus.alarm_arm = 1'b0;
    do_set(2021, 1, 1, 7, 29, 59);
    for (int i = 0; i < 2 * CLK_HZ; i++) step();
    checks++;
    if (bus.alarm !== 1'b0) begin
      errors++; $display("[TB] FAIL alarm_disarmed got %b want 0", bus.alarm);
    end
  endtask
`endif

  initial begin
    bus.set_en     = 1'b0;
    bus.set_year   = '0;
    bus.set_month  = '0;
    bus.set_day    = '0;
    bus.set_hour   = '0;
    bus.set_minute = '0;
    bus.set_second = '0;
`ifdef ALARM_EN
    bus.alarm_hour   = '0;
    bus.alarm_minute = '0;
    bus.alarm_arm    = 1'b0;
    bus.alarm_clr    = 1'b0;
`endif
    test_reset();
    test_rollover("leap_feb", 2024, 2, 28, 23, 59, 59);
    test_rollover("century_nonleap", 2100, 2, 28, 23, 59, 59);
    test_rollover("y2k_feb29", 2000, 2, 29, 23, 59, 59);
    test_rollover("year_end", 2021, 12, 31, 23, 59, 59);
    test_rollover("year_wrap", 4095, 12, 31, 23, 59, 59);
    test_rollover("hour_carry", 2022, 6, 15, 8, 59, 59);
    test_invalid_set();
    test_set_on_terminal();
    test_back_to_back();
    test_random();
    test_reset_midcount();
`ifdef ALARM_EN
    test_alarm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
